// File: rtl/sgen_nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// sgen_nco_sweep_ctrl
//
// Frequency-sweep sequencer in front of sgen_nco. It steps the NCO frequency
// control word (FCW) from a start value to a stop value. Each value is held for
// a programmable dwell. Three sweep shapes are supported: single, repeating
// sawtooth and continuous triangle. This block owns the NCO enable.
//
// Ports:
//   i_clk        system clock
//   i_rst_an     synchronous active-low reset
//   i_ena        clock enable; 0 freezes all state (pulse outputs still clear)
//   i_start      start request, level sampled while idle
//   i_abort      stop the sweep immediately; has priority over i_start
//   i_mode       00 single, 01 repeat sawtooth, 10 triangle, 11 as single
//   i_fcw_start  first FCW (unsigned)
//   i_fcw_stop   last FCW (unsigned)
//   i_fcw_step   FCW increment (unsigned, must be non-zero)
//   i_dwell      each FCW is held for i_dwell+1 enabled cycles
//   o_fcw        FCW to the NCO
//   o_nco_ena    NCO enable
//   o_busy       sweep in progress
//   o_step       1-cycle pulse when o_fcw takes a new value
//   o_done       1-cycle pulse at normal end of a single sweep
//   o_err        1-cycle pulse when a start request is rejected
// -----------------------------------------------------------------------------
module sgen_nco_sweep_ctrl #(
   parameter int gp_phase_accu_width = 16,
   parameter int gp_dwell_width      = 16
) (
   input  logic                           i_clk,
   input  logic                           i_rst_an,
   input  logic                           i_ena,
   input  logic                           i_start,
   input  logic                           i_abort,
   input  logic [1:0]                     i_mode,
   input  logic [gp_phase_accu_width-1:0] i_fcw_start,
   input  logic [gp_phase_accu_width-1:0] i_fcw_stop,
   input  logic [gp_phase_accu_width-1:0] i_fcw_step,
   input  logic [gp_dwell_width-1:0]      i_dwell,
   output logic [gp_phase_accu_width-1:0] o_fcw,
   output logic                           o_nco_ena,
   output logic                           o_busy,
   output logic                           o_step,
   output logic                           o_done,
   output logic                           o_err
);

   localparam int W = gp_phase_accu_width;
   localparam int D = gp_dwell_width;

   localparam logic [1:0] MODE_REPEAT = 2'b01;
   localparam logic [1:0] MODE_TRI    = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b01,
      ST_DN   = 2'b10
   } state_t;

   state_t         state_r,   state_s;
   logic [W-1:0]   fcw_r,     fcw_s;
   logic [W-1:0]   start_r,   start_s;
   logic [W-1:0]   stop_r,    stop_s;
   logic [W-1:0]   step_r,    step_s;
   logic [D-1:0]   dwell_r,   dwell_s;
   logic [1:0]     mode_r,    mode_s;
   logic [D-1:0]   cnt_r,     cnt_s;
   logic           busy_r,    busy_s;
   logic           nco_ena_r, nco_ena_s;
   logic           step_p_r,  step_p_s;
   logic           done_r,    done_s;
   logic           err_r,     err_s;

   // Candidate next values; the sum is one bit wider so it cannot wrap, and
   // the subtract first measures the distance to start so it cannot borrow.
   logic [W:0]     sum_s;
   logic [W-1:0]   up_val_s;
   logic [W-1:0]   diff_s;
   logic [W-1:0]   dn_val_s;
   logic           dwell_hit_s;

   // Next-state and datapath decode for the sweep sequencer.
   always_comb begin
      state_s   = state_r;
      fcw_s     = fcw_r;
      start_s   = start_r;
      stop_s    = stop_r;
      step_s    = step_r;
      dwell_s   = dwell_r;
      mode_s    = mode_r;
      cnt_s     = cnt_r;
      busy_s    = busy_r;
      nco_ena_s = nco_ena_r;
      step_p_s  = 1'b0;
      done_s    = 1'b0;
      err_s     = 1'b0;

      sum_s       = {1'b0, fcw_r} + {1'b0, step_r};
      up_val_s    = (sum_s > {1'b0, stop_r}) ? stop_r : sum_s[W-1:0];
      diff_s      = fcw_r - start_r;
      dn_val_s    = (diff_s >= step_r) ? (fcw_r - step_r) : start_r;
      dwell_hit_s = (cnt_r == dwell_r);

      if (i_abort) begin
         state_s   = ST_IDLE;
         fcw_s     = {W{1'b0}};
         cnt_s     = {D{1'b0}};
         busy_s    = 1'b0;
         nco_ena_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_start) begin
                  if ((i_fcw_start > i_fcw_stop) || (i_fcw_step == {W{1'b0}})) begin
                     err_s = 1'b1;
                  end else begin
                     start_s   = i_fcw_start;
                     stop_s    = i_fcw_stop;
                     step_s    = i_fcw_step;
                     dwell_s   = i_dwell;
                     mode_s    = i_mode;
                     fcw_s     = i_fcw_start;
                     cnt_s     = {D{1'b0}};
                     busy_s    = 1'b1;
                     nco_ena_s = 1'b1;
                     step_p_s  = 1'b1;
                     state_s   = ST_UP;
                  end
               end else begin
                  state_s = ST_IDLE;
               end
            end

            ST_UP: begin
               if (dwell_hit_s) begin
                  cnt_s = {D{1'b0}};
                  if (fcw_r < stop_r) begin
                     fcw_s    = up_val_s;
                     step_p_s = 1'b1;
                  end else begin
                     case (mode_r)
                        MODE_REPEAT: begin
                           fcw_s    = start_r;
                           step_p_s = 1'b1;
                        end
                        MODE_TRI: begin
                           // A zero-span triangle has no down leg.
                           if (start_r == stop_r) begin
                              fcw_s   = start_r;
                              state_s = ST_UP;
                           end else begin
                              fcw_s   = dn_val_s;
                              state_s = ST_DN;
                           end
                           step_p_s = 1'b1;
                        end
                        default: begin
                           state_s   = ST_IDLE;
                           fcw_s     = {W{1'b0}};
                           busy_s    = 1'b0;
                           nco_ena_s = 1'b0;
                           done_s    = 1'b1;
                        end
                     endcase
                  end
               end else begin
                  cnt_s = cnt_r + 1'b1;
               end
            end

            ST_DN: begin
               if (dwell_hit_s) begin
                  cnt_s    = {D{1'b0}};
                  step_p_s = 1'b1;
                  if (fcw_r > start_r) begin
                     fcw_s = dn_val_s;
                  end else begin
                     // fcw equals start here, so up_val_s is min(start+step, stop).
                     fcw_s   = up_val_s;
                     state_s = ST_UP;
                  end
               end else begin
                  cnt_s = cnt_r + 1'b1;
               end
            end

            default: begin
               state_s   = ST_IDLE;
               fcw_s     = {W{1'b0}};
               cnt_s     = {D{1'b0}};
               busy_s    = 1'b0;
               nco_ena_s = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; pulses self-clear even while disabled.
   always_ff @(posedge i_clk) begin
      if (!i_rst_an) begin
         state_r   <= ST_IDLE;
         fcw_r     <= {W{1'b0}};
         start_r   <= {W{1'b0}};
         stop_r    <= {W{1'b0}};
         step_r    <= {W{1'b0}};
         dwell_r   <= {D{1'b0}};
         mode_r    <= 2'b00;
         cnt_r     <= {D{1'b0}};
         busy_r    <= 1'b0;
         nco_ena_r <= 1'b0;
         step_p_r  <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
      end else if (i_ena) begin
         state_r   <= state_s;
         fcw_r     <= fcw_s;
         start_r   <= start_s;
         stop_r    <= stop_s;
         step_r    <= step_s;
         dwell_r   <= dwell_s;
         mode_r    <= mode_s;
         cnt_r     <= cnt_s;
         busy_r    <= busy_s;
         nco_ena_r <= nco_ena_s;
         step_p_r  <= step_p_s;
         done_r    <= done_s;
         err_r     <= err_s;
      end else begin
         step_p_r  <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
      end
   end

   assign o_fcw     = fcw_r;
   assign o_nco_ena = nco_ena_r;
   assign o_busy    = busy_r;
   assign o_step    = step_p_r;
   assign o_done    = done_r;
   assign o_err     = err_r;

endmodule

// File: tb/tb_sgen_nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for sgen_nco_sweep_ctrl. The expected FCW sequence of each sweep
// is built as a list of distinct values. Every enabled cycle is then checked
// against list[(cycle / (dwell+1)) mod period].
// -----------------------------------------------------------------------------
module tb_sgen_nco_sweep_ctrl;

   localparam int W = 16;
   localparam int D = 16;

   logic         clk = 1'b0;
   logic         i_rst_an;
   logic         i_ena;
   logic         i_start;
   logic         i_abort;
   logic [1:0]   i_mode;
   logic [W-1:0] i_fcw_start;
   logic [W-1:0] i_fcw_stop;
   logic [W-1:0] i_fcw_step;
   logic [D-1:0] i_dwell;
   logic [W-1:0] o_fcw;
   logic         o_nco_ena;
   logic         o_busy;
   logic         o_step;
   logic         o_done;
   logic         o_err;

   int checks = 0;
   int errors = 0;

   sgen_nco_sweep_ctrl #(
      .gp_phase_accu_width (W),
      .gp_dwell_width      (D)
   ) dut (
      .i_clk       (clk),
      .i_rst_an    (i_rst_an),
      .i_ena       (i_ena),
      .i_start     (i_start),
      .i_abort     (i_abort),
      .i_mode      (i_mode),
      .i_fcw_start (i_fcw_start),
      .i_fcw_stop  (i_fcw_stop),
      .i_fcw_step  (i_fcw_step),
      .i_dwell     (i_dwell),
      .o_fcw       (o_fcw),
      .o_nco_ena   (o_nco_ena),
      .o_busy      (o_busy),
      .o_step      (o_step),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: bench did not complete within time budget");
      $fatal(1, "timeout");
   end

   // Runs one sweep from IDLE and checks every cycle against the value-list model.
   // Single sweeps run to done plus one idle cycle. Other modes run ncyc cycles and stay busy.
   task automatic run_sweep(input string tag, input logic [1:0] mode, input int s, input int p,
                            input int st, input int dw, input int ncyc, input int freeze_at,
                            input bit noisy);
      int          up_q[$];
      int          per_q[$];
      int          v;
      int          total;
      int          n;
      int          idx;
      bit          single;
      int          exp_fcw;
      bit          exp_step;
      bit          exp_busy;
      bit          exp_done;
      logic [20:0] obs;
      logic [20:0] expv;
      single = (mode == 2'b00) || (mode == 2'b11);
      v = s;
      up_q.push_back(v);
      while (v < p) begin
         v = (v + st > p) ? p : v + st;
         up_q.push_back(v);
      end
      per_q = up_q;
      if (mode == 2'b10) begin
         v = p;
         while (v > s) begin
            v = (v - s >= st) ? v - st : s;
            if (v > s) per_q.push_back(v);
         end
      end
      total = up_q.size() * (dw + 1);
      n = single ? total + 2 : ncyc;

      i_fcw_start = W'(s);
      i_fcw_stop  = W'(p);
      i_fcw_step  = W'(st);
      i_dwell     = D'(dw);
      i_mode      = mode;
      i_start     = 1'b1;
      @(negedge clk);
      for (int k = 0; k < n; k++) begin
         idx = k / (dw + 1);
         if (single && (k >= total)) begin
            exp_fcw  = 0;
            exp_step = 1'b0;
            exp_busy = 1'b0;
            exp_done = (k == total);
         end else begin
            exp_fcw  = per_q[idx % per_q.size()];
            exp_step = ((k % (dw + 1)) == 0);
            exp_busy = 1'b1;
            exp_done = 1'b0;
         end
         expv = {W'(exp_fcw), exp_step, exp_busy, exp_busy, exp_done, 1'b0};
         obs  = {o_fcw, o_step, o_busy, o_nco_ena, o_done, o_err};
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got fcw=%0d step/busy/ena/done/err=%05b, expected fcw=%0d %05b",
                     tag, k, o_fcw, obs[4:0], exp_fcw, expv[4:0]);
         end
         if (noisy && (!single || (k < total))) begin
            i_start     = 1'($urandom_range(0, 1));
            i_fcw_start = W'($urandom);
            i_fcw_stop  = W'($urandom);
            i_fcw_step  = W'($urandom);
            i_dwell     = D'($urandom);
            i_mode      = 2'($urandom);
         end else begin
            i_start = 1'b0;
         end
         if (k == freeze_at) begin
            i_ena = 1'b0;
            repeat (5) begin
               @(negedge clk);
               expv = {W'(exp_fcw), 1'b0, exp_busy, exp_busy, 1'b0, 1'b0};
               obs  = {o_fcw, o_step, o_busy, o_nco_ena, o_done, o_err};
               checks++;
               if (obs !== expv) begin
                  errors++;
                  $display("FAIL %s_freeze: got fcw=%0d flags=%05b, expected fcw=%0d flags=%05b",
                           tag, o_fcw, obs[4:0], exp_fcw, expv[4:0]);
               end
            end
            i_ena = 1'b1;
         end
         @(negedge clk);
      end
      i_start = 1'b0;
   endtask

   // Aborts a running sweep and expects every output to be zero one cycle later.
   task automatic abort_and_check(input string tag);
      logic [20:0] obs;
      i_start = 1'b0;
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      obs = {o_fcw, o_step, o_busy, o_nco_ena, o_done, o_err};
      checks++;
      if (obs !== 21'd0) begin
         errors++;
         $display("FAIL %s: got fcw=%0d flags=%05b, expected all zero", tag, o_fcw, obs[4:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [20:0] obs;
      i_rst_an = 1'b0;
      repeat (3) @(negedge clk);
      obs = {o_fcw, o_step, o_busy, o_nco_ena, o_done, o_err};
      checks++;
      if (obs !== 21'd0) begin
         errors++;
         $display("FAIL reset: got fcw=%0d flags=%05b, expected all zero", o_fcw, obs[4:0]);
      end
      i_rst_an = 1'b1;
      @(negedge clk);
      obs = {o_fcw, o_step, o_busy, o_nco_ena, o_done, o_err};
      checks++;
      if (obs !== 21'd0) begin
         errors++;
         $display("FAIL post_reset_idle: got fcw=%0d flags=%05b, expected all zero", o_fcw, obs[4:0]);
      end
   endtask

   task automatic test_single();
      run_sweep("single", 2'b00, 100, 130, 10, 2, 0, -1, 1'b0);
      run_sweep("single_mode3", 2'b11, 7, 7, 3, 4, 0, -1, 1'b0);
   endtask

   task automatic test_clamp();
      run_sweep("clamp", 2'b00, 65500, 65530, 20, 0, 0, -1, 1'b0);
      run_sweep("clamp_top", 2'b00, 65000, 65535, 200, 0, 0, -1, 1'b0);
   endtask

   task automatic test_triangle();
      run_sweep("triangle", 2'b10, 10, 40, 15, 0, 17, -1, 1'b0);
      abort_and_check("triangle_abort");
      run_sweep("triangle_odd", 2'b10, 0, 10, 4, 1, 30, -1, 1'b0);
      abort_and_check("triangle_odd_abort");
   endtask

   task automatic test_repeat_freeze();
      run_sweep("repeat", 2'b01, 0, 4, 2, 1, 16, 4, 1'b0);
      abort_and_check("repeat_abort");
   endtask

   task automatic test_rejects();
      logic [20:0] obs;
      i_fcw_start = 16'd50;
      i_fcw_stop  = 16'd40;
      i_fcw_step  = 16'd5;
      i_dwell     = 16'd0;
      i_mode      = 2'b00;
      i_start     = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      obs = {o_fcw, o_step, o_busy, o_nco_ena, o_done, o_err};
      checks++;
      if (obs !== 21'd1) begin
         errors++;
         $display("FAIL reject_order: got flags=%05b fcw=%0d, expected err only", obs[4:0], o_fcw);
      end
      @(negedge clk);
      obs = {o_fcw, o_step, o_busy, o_nco_ena, o_done, o_err};
      checks++;
      if (obs !== 21'd0) begin
         errors++;
         $display("FAIL reject_err_clear: got flags=%05b, expected zero", obs[4:0]);
      end
      i_fcw_start = 16'd10;
      i_fcw_stop  = 16'd20;
      i_fcw_step  = 16'd0;
      i_start     = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      obs = {o_fcw, o_step, o_busy, o_nco_ena, o_done, o_err};
      checks++;
      if (obs !== 21'd1) begin
         errors++;
         $display("FAIL reject_step0: got flags=%05b fcw=%0d, expected err only", obs[4:0], o_fcw);
      end
      @(negedge clk);
      i_fcw_step = 16'd3;
      i_start    = 1'b1;
      i_abort    = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_abort = 1'b0;
      obs = {o_fcw, o_step, o_busy, o_nco_ena, o_done, o_err};
      checks++;
      if (obs !== 21'd0) begin
         errors++;
         $display("FAIL start_with_abort: got flags=%05b fcw=%0d, expected idle", obs[4:0], o_fcw);
      end
      run_sweep("busy_start_ignored", 2'b00, 200, 260, 20, 1, 0, -1, 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [20:0] obs;
      i_fcw_start = 16'd100;
      i_fcw_stop  = 16'd200;
      i_fcw_step  = 16'd10;
      i_dwell     = 16'd1;
      i_mode      = 2'b00;
      i_start     = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (o_busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_busy: got busy=%0b, expected 1", o_busy);
      end
      i_rst_an = 1'b0;
      @(negedge clk);
      i_rst_an = 1'b1;
      obs = {o_fcw, o_step, o_busy, o_nco_ena, o_done, o_err};
      checks++;
      if (obs !== 21'd0) begin
         errors++;
         $display("FAIL reset_mid: got fcw=%0d flags=%05b, expected all zero", o_fcw, obs[4:0]);
      end
      @(negedge clk);
      obs = {o_fcw, o_step, o_busy, o_nco_ena, o_done, o_err};
      checks++;
      if (obs !== 21'd0) begin
         errors++;
         $display("FAIL reset_mid_no_done: got fcw=%0d flags=%05b, expected all zero", o_fcw, obs[4:0]);
      end
      run_sweep("after_reset", 2'b00, 100, 130, 10, 2, 0, -1, 1'b0);
   endtask

   task automatic test_random();
      int stop_v;
      int span;
      int start_v;
      int step_v;
      int dw;
      logic [1:0] mode;
      for (int it = 0; it < 10; it++) begin
         stop_v  = (it % 4 == 0) ? 65535 : int'($urandom_range(0, 65535));
         span    = $urandom_range(0, 120);
         start_v = (stop_v >= span) ? stop_v - span : 0;
         step_v  = $urandom_range(1, 70);
         dw      = $urandom_range(0, 3);
         mode    = 2'($urandom_range(0, 3));
         run_sweep("random", mode, start_v, stop_v, step_v, dw,
                   int'($urandom_range(10, 60)), -1, 1'b1);
         if (!((mode == 2'b00) || (mode == 2'b11))) begin
            abort_and_check("random_abort");
         end
      end
   endtask

   initial begin
      i_rst_an    = 1'b0;
      i_ena       = 1'b1;
      i_start     = 1'b0;
      i_abort     = 1'b0;
      i_mode      = 2'b00;
      i_fcw_start = 16'd0;
      i_fcw_stop  = 16'd0;
      i_fcw_step  = 16'd0;
      i_dwell     = 16'd0;
      @(negedge clk);
      test_reset();
      test_single();
      test_clamp();
      test_triangle();
      test_repeat_freeze();
      test_rejects();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
